// File: rtl/hit_judge.sv
// hit_judge: judges keypad presses against each light window and keeps game score.
// Optional STREAK_EN adds current and best hit-streak outputs.
module hit_judge #(
  parameter int unsigned CW             = 6,
  parameter bit          WRONG_KEY_MISS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          light_off,
  input  logic [3:0]    light_coord,
  input  logic          key_valid,
  input  logic [3:0]    key,
  input  logic [CW-1:0] max_hits,
  input  logic [1:0]    total_lives,
  output logic [CW-1:0] points,
  output logic [CW-1:0] flicks,
  output logic [CW-1:0] misses,
  output logic [1:0]    lives_left,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output logic          game_over
`ifdef STREAK_EN
  ,
  output logic [CW-1:0] streak,
  output logic [CW-1:0] best_streak
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ARMED, S_JUDGED, S_DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        r_state, w_state_nxt;
  logic          r_light_off_d, r_key_valid_d;
  logic [3:0]    r_coord, w_coord_nxt;
  logic [CW-1:0] r_points, w_points_nxt;
  logic [CW-1:0] r_flicks, w_flicks_nxt;
  logic [CW-1:0] r_misses, w_misses_nxt;
  logic [1:0]    r_lives_left, w_lives_nxt;
  logic          r_hit_pulse, w_hit_nxt;
  logic          r_miss_pulse, w_miss_nxt;
  logic          r_game_over;
`ifdef STREAK_EN
  logic [CW-1:0] r_streak, w_streak_nxt;
  logic [CW-1:0] r_best_streak;
`endif

  logic w_open, w_close, w_press, w_hit_ev, w_miss_ev, w_active, w_over;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  assign w_open   = r_light_off_d & ~light_off;
  assign w_close  = ~r_light_off_d & light_off;
  assign w_press  = ~r_key_valid_d & key_valid;
  assign w_active = (r_state == S_WAIT) || (r_state == S_ARMED) || (r_state == S_JUDGED);
  assign w_over   = (r_flicks == max_hits) ||
                    ((total_lives != 2'd0) && (r_lives_left == 2'd0));

  // A wrong key coinciding with a close still yields a single miss
  assign w_hit_ev  = w_press && (key == r_coord);
  assign w_miss_ev = (w_press && !w_hit_ev && WRONG_KEY_MISS) || (w_close && !w_hit_ev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_coord_nxt  = r_coord;
    w_points_nxt = r_points;
    w_flicks_nxt = r_flicks;
    w_misses_nxt = r_misses;
    w_lives_nxt  = r_lives_left;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
`ifdef STREAK_EN
    w_streak_nxt = r_streak;
`endif
    if (w_active && !start) begin
      w_state_nxt = S_IDLE;
    end else if (w_active && w_over) begin
      w_state_nxt = S_DONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_lives_nxt = total_lives;
          if (start) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (w_open) begin
            w_coord_nxt = light_coord;
            w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_hit_ev) begin
            w_points_nxt = sat_inc(r_points);
            w_hit_nxt    = 1'b1;
`ifdef STREAK_EN
            w_streak_nxt = sat_inc(r_streak);
`endif
          end
          if (w_miss_ev) begin
            w_misses_nxt = sat_inc(r_misses);
            w_miss_nxt   = 1'b1;
            if ((total_lives != 2'd0) && (r_lives_left != 2'd0))
              w_lives_nxt = r_lives_left - 2'd1;
`ifdef STREAK_EN
            w_streak_nxt = '0;
`endif
          end
          if (w_close) begin
            w_flicks_nxt = sat_inc(r_flicks);
            w_state_nxt  = S_WAIT;
          end else if (w_hit_ev || w_miss_ev) begin
            w_state_nxt = S_JUDGED;
          end
        end
        S_JUDGED: begin
          if (w_close) begin
            w_flicks_nxt = sat_inc(r_flicks);
            w_state_nxt  = S_WAIT;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_light_off_d <= 1'b1;
      r_key_valid_d <= 1'b1;
      r_coord       <= '0;
      r_points      <= '0;
      r_flicks      <= '0;
      r_misses      <= '0;
      r_lives_left  <= '0;
      r_hit_pulse   <= 1'b0;
      r_miss_pulse  <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_light_off_d <= light_off;
      r_key_valid_d <= key_valid;
      r_coord       <= w_coord_nxt;
      r_points      <= w_points_nxt;
      r_flicks      <= w_flicks_nxt;
      r_misses      <= w_misses_nxt;
      r_lives_left  <= w_lives_nxt;
      r_hit_pulse   <= w_hit_nxt;
      r_miss_pulse  <= w_miss_nxt;
      r_game_over   <= (w_state_nxt == S_DONE);
    end
  end

`ifdef STREAK_EN
  // Best streak trails the live streak by one cycle and freezes in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak      <= '0;
      r_best_streak <= '0;
    end else begin
      r_streak <= w_streak_nxt;
      if ((r_state != S_DONE) && (r_streak > r_best_streak))
        r_best_streak <= r_streak;
    end
  end

  assign streak      = r_streak;
  assign best_streak = r_best_streak;
`endif

  assign points     = r_points;
  assign flicks     = r_flicks;
  assign misses     = r_misses;
  assign lives_left = r_lives_left;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign game_over  = r_game_over;

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Scoring stage between the light controller and keypad controller and the game FSM.
- Watches each light window, judges keypad presses against the lit position, and counts hits, flicks, misses and lives.
- Raises game_over for the top-level state machine, which drives the GAME_OVER transition.
- Replaces ad-hoc hit/flick counting in the top level with one clocked block.

Parameters:
- CW, 6, width of points/flicks/misses counters; all saturate at 2^CW-1.
- WRONG_KEY_MISS, 1, 1: a wrong key closes the window as a miss; 0: wrong keys are ignored.

Ports:
- clk  input  1  system clock (CLOCK_50 at top).
- reset  input  1  asynchronous, active-high; clears all state (driven from clear_memory).
- start  input  1  level; game running; judging only while high.
- light_off  input  1  level from light controller btwn_light; high = between lights, low = light lit.
- light_coord  input  4  keypad code of the lit position, valid while light_off low.
- key_valid  input  1  level from keypad controller; a rising edge marks a new press.
- key  input  4  key code, valid in the cycle key_valid is high.
- max_hits  input  CW  flicks per game (25 or 50).
- total_lives  input  2  0 = unlimited lives, else starting lives.
- points  output  CW  hits scored.
- flicks  output  CW  completed light windows.
- misses  output  CW  windows ended without a hit.
- lives_left  output  2  remaining lives; reads total_lives while IDLE.
- hit_pulse  output  1  one-cycle pulse on a judged hit.
- miss_pulse  output  1  one-cycle pulse on a judged miss.
- game_over  output  1  level; held until reset.

Behaviour:
- Reset values: points/flicks/misses = 0, lives_left = 0, pulses = 0, game_over = 0, state IDLE.
- Edge detect: light_off and key_valid each registered once. Their reset values are 1 and 1, so no edge is seen out of reset.
  - Window open = light_off falling edge.
  - Window close = light_off rising edge.
  - Press = key_valid rising edge.
- State IDLE:
  - lives_left <= total_lives every cycle.
  - On start=1 go to WAIT.
- State WAIT (between lights):
  - Window open captures light_coord into an internal register and moves to ARMED.
  - Presses are ignored.
- State ARMED (light lit, no judgement yet), on a press:
  - key == captured coord: points+1, hit_pulse, go to JUDGED.
  - Otherwise, with WRONG_KEY_MISS=1: misses+1, miss_pulse, lose a life, go to JUDGED.
  - Otherwise, with WRONG_KEY_MISS=0: stay in ARMED.
- ARMED, window close without a judgement: misses+1, miss_pulse, lose a life, flicks+1, go to WAIT.
- State JUDGED: further presses are ignored. Window close: flicks+1, go to WAIT.
- Same-cycle press and window close in ARMED:
  - The press is judged first.
  - A hit gives exactly one hit and one flick.
  - A wrong key gives exactly one miss and one flick; never a double miss.
- Lose a life:
  - Only when total_lives != 0.
  - lives_left decrements and saturates at 0.
- State DONE (game_over=1):
  - Counters are frozen and pulses are 0.
  - Left only by reset.
- Game-over condition, evaluated on the registered values one cycle after an update:
  - flicks == max_hits, or
  - total_lives != 0 and lives_left == 0.
  - Enter DONE and assert game_over the next cycle. Latency is 2 clk from the causing edge.
- start falling in any non-DONE state:
  - Return to IDLE and hold the counters.
  - A pending window is discarded without a miss.
- Counters saturate at 2^CW-1 and never wrap.
- max_hits = 0: game_over after the first completed flick check, i.e. immediately once in WAIT (flicks 0 == 0).
- Reset mid-window: everything clears asynchronously. The next window open is needed before judging resumes.

Optional Feature:
- Macro STREAK_EN.
- Defined:
  - Adds outputs streak [CW-1:0] and best_streak [CW-1:0], both reset to 0.
  - A hit increments streak.
  - A miss clears streak to 0.
  - best_streak <= max(best_streak, streak) the cycle after each update.
  - Both are frozen in DONE.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, start=1, total_lives=0, max_hits=25, 25 windows each with a matching press -> points=25, flicks=25, misses=0, game_over=1 2 cycles after the 25th close.
- total_lives=1, one window closes with no press -> misses=1, lives_left=0, miss_pulse once, game_over=1, flicks=1.
- WRONG_KEY_MISS=1, light_coord=4'h5, presses 4'h3 then 4'h5 in the same window -> misses=1, points=0, one miss_pulse, then flicks=1 at close.
- Press with key==coord on the same cycle as window close -> points=1, flicks=1, misses=0, exactly one hit_pulse.
- Assert reset mid-window with points=7 -> all outputs 0 immediately; no judgement until the next light_off falling edge after start.
- STREAK_EN: hit,hit,hit,miss,hit -> streak=1, best_streak=3.
